// File: rtl/regfile_pkg.sv
// Shared definitions for the regfile access controller: FSM state encoding,
// MIPS instruction field positions and well-known register/opcode values.
package regfile_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 11;

  localparam logic [5:0] OPC_RTYPE = 6'd0;
  localparam logic [4:0] REG_ZERO  = 5'd0;

  // READ spends this many cycles presenting the read addresses before the
  // capture cycle (the address registers update one edge after entry).
  localparam logic [1:0] RD_SETUP_CNT = 2'd1;

  function automatic logic is_rtype(input logic [5:0] opc);
    return (opc == OPC_RTYPE);
  endfunction

endpackage

// File: rtl/regfile_access_ctrl_operand_sel.sv
// rf_operand_sel: resolves one operand value from the regfile read data.
// Forces $zero reads to 0 and flags a same-register writeback collision.
// With REGFILE_BYPASS_EN defined, a colliding writeback value is forwarded.
module rf_operand_sel
  import regfile_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 5
) (
  input  logic [AWIDTH-1:0] addr,
  input  logic [DWIDTH-1:0] rf_dout,
  input  logic              wb_valid,
  input  logic [AWIDTH-1:0] wb_addr,
  input  logic [DWIDTH-1:0] wb_data,
  output logic [DWIDTH-1:0] operand,
  output logic              collide
);

  // A write to $zero never reaches the regfile, so it can never collide.
  assign collide = wb_valid && (wb_addr != AWIDTH'(REG_ZERO)) && (wb_addr == addr);

`ifdef REGFILE_BYPASS_EN
`else
  logic unused_wb_data;
  assign unused_wb_data = ^wb_data;
`endif

  // Operand selection: regfile data, optional forwarding, $zero forcing last.
  always_comb begin
    operand = rf_dout;
`ifdef REGFILE_BYPASS_EN
    if (collide) operand = wb_data;
`endif
    if (addr == AWIDTH'(REG_ZERO)) operand = '0;
  end

endmodule

// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl: requester side of the regfile. Decodes rs/rt/dst from
// an instruction, reads both operands and holds them under valid/ready, and
// passes writebacks straight through to the regfile write port.
// Optional macro REGFILE_BYPASS_EN: forward colliding writeback data instead
// of stalling one cycle in READ.
//
// state | meaning
// IDLE  | ready for an instruction
// READ  | read addresses set up, then operands captured (one stall on collision without bypass)
// HOLD  | operands valid, waiting for op_ready
module regfile_access_ctrl
  import regfile_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DWIDTH-1:0] op_a,
  output logic [DWIDTH-1:0] op_b,
  output logic [AWIDTH-1:0] op_dst,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [AWIDTH-1:0] wb_addr,
  input  logic [DWIDTH-1:0] wb_data,
  output logic [AWIDTH-1:0] rf_rdaddr1,
  output logic [AWIDTH-1:0] rf_rdaddr2,
  output logic [AWIDTH-1:0] rf_wraddr,
  output logic              rf_wr,
  output logic [DWIDTH-1:0] rf_din,
  input  logic [DWIDTH-1:0] rf_dout1,
  input  logic [DWIDTH-1:0] rf_dout2
);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_READ = ST_READ;
  localparam logic [1:0] S_HOLD = ST_HOLD;

  logic [1:0]        state;
  logic [1:0]        rd_cnt;
  logic              stall_done;
  logic [AWIDTH-1:0] rs_q;
  logic [AWIDTH-1:0] rt_q;
  logic [AWIDTH-1:0] dst_q;
  logic [DWIDTH-1:0] op_a_q;
  logic [DWIDTH-1:0] op_b_q;
  logic [AWIDTH-1:0] rdaddr1_q;
  logic [AWIDTH-1:0] rdaddr2_q;

  logic [DWIDTH-1:0] sel_a;
  logic [DWIDTH-1:0] sel_b;
  logic              col_a;
  logic              col_b;
  logic              need_stall;

  logic [5:0]        f_opc;
  logic [AWIDTH-1:0] f_rs;
  logic [AWIDTH-1:0] f_rt;
  logic [AWIDTH-1:0] f_rd;
  logic              unused_instr_low;

  assign f_opc = instr[OPC_MSB:OPC_LSB];
  assign f_rs  = AWIDTH'(instr[RS_MSB:RS_LSB]);
  assign f_rt  = AWIDTH'(instr[RT_MSB:RT_LSB]);
  assign f_rd  = AWIDTH'(instr[RD_MSB:RD_LSB]);
  assign unused_instr_low = ^instr[RD_LSB-1:0];

  // Writeback is a pure pass-through; $zero writes are swallowed here.
  assign wb_ready  = 1'b1;
  assign rf_wraddr = wb_addr;
  assign rf_din    = wb_data;
  assign rf_wr     = wb_valid && (wb_addr != AWIDTH'(REG_ZERO));

  assign instr_ready = (state == S_IDLE);
  assign op_valid    = (state == S_HOLD);
  assign op_a        = op_a_q;
  assign op_b        = op_b_q;
  assign op_dst      = dst_q;
  assign rf_rdaddr1  = rdaddr1_q;
  assign rf_rdaddr2  = rdaddr2_q;

  rf_operand_sel #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) u_sel_rs (
    .addr     (rs_q),
    .rf_dout  (rf_dout1),
    .wb_valid (wb_valid),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .operand  (sel_a),
    .collide  (col_a)
  );

  rf_operand_sel #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) u_sel_rt (
    .addr     (rt_q),
    .rf_dout  (rf_dout2),
    .wb_valid (wb_valid),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .operand  (sel_b),
    .collide  (col_b)
  );

`ifdef REGFILE_BYPASS_EN
  logic unused_col;
  assign unused_col = col_a ^ col_b ^ stall_done;
  assign need_stall = 1'b0;
`else
  // Let the colliding write commit, then re-read the regfile once.
  assign need_stall = (col_a || col_b) && !stall_done;
`endif

  // Controller FSM with read-address registers and operand capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      rd_cnt     <= '0;
      stall_done <= 1'b0;
      rs_q       <= '0;
      rt_q       <= '0;
      dst_q      <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      rdaddr1_q  <= '0;
      rdaddr2_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (instr_valid) begin
            rs_q       <= f_rs;
            rt_q       <= f_rt;
            dst_q      <= is_rtype(f_opc) ? f_rd : f_rt;
            rd_cnt     <= RD_SETUP_CNT;
            stall_done <= 1'b0;
            state      <= S_READ;
          end
        end
        S_READ: begin
          if (rd_cnt != 2'd0) begin
            rd_cnt    <= rd_cnt - 2'd1;
            rdaddr1_q <= rs_q;
            rdaddr2_q <= rt_q;
          end else if (need_stall) begin
            stall_done <= 1'b1;
          end else begin
            op_a_q <= sel_a;
            op_b_q <= sel_b;
            state  <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (op_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Self-checking bench for regfile_access_ctrl with a behavioural regfile.
module tb_regfile_access_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] instr = '0;
  logic        op_valid;
  logic        op_ready = 1'b0;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  op_dst;
  logic        wb_valid = 1'b0;
  logic        wb_ready;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic [4:0]  rf_rdaddr1;
  logic [4:0]  rf_rdaddr2;
  logic [4:0]  rf_wraddr;
  logic        rf_wr;
  logic [31:0] rf_din;
  logic [31:0] rf_dout1;
  logic [31:0] rf_dout2;

  int checks = 0;
  int errors = 0;

`ifdef REGFILE_BYPASS_EN
  localparam int COL_LAT = 2;
`else
  localparam int COL_LAT = 3;
`endif

  always #5 clk = ~clk;

  regfile_access_ctrl #(.DWIDTH(32), .AWIDTH(5)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b), .op_dst(op_dst),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
    .rf_rdaddr1(rf_rdaddr1), .rf_rdaddr2(rf_rdaddr2),
    .rf_wraddr(rf_wraddr), .rf_wr(rf_wr), .rf_din(rf_din),
    .rf_dout1(rf_dout1), .rf_dout2(rf_dout2)
  );

  // Regfile model: combinational reads, write at rising edge. Register 0
  // returns junk so that the controller's zero forcing is observable.
  logic [31:0] mem [32];
  assign rf_dout1 = (rf_rdaddr1 == 5'd0) ? 32'hDEADBEEF : mem[rf_rdaddr1];
  assign rf_dout2 = (rf_rdaddr2 == 5'd0) ? 32'hDEADBEEF : mem[rf_rdaddr2];
  always @(posedge clk) if (rf_wr) mem[rf_wraddr] <= rf_din;

  typedef struct {
    logic [5:0]  opc;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic [4:0]  exp_dst;
  } vec_t;

  vec_t vecs [5];

  function automatic logic [31:0] mk(input logic [5:0] opc, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [4:0] rd);
    return {opc, rs, rt, rd, 11'h155};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    wb_valid = 1'b1; wb_addr = a; wb_data = d;
    #1;
    chk("wb_ready", {31'd0, wb_ready}, 32'd1);
    chk("rf_wr", {31'd0, rf_wr}, {31'd0, (a != 5'd0)});
    if (a != 5'd0) begin
      chk("rf_wraddr", {27'd0, rf_wraddr}, {27'd0, a});
      chk("rf_din", rf_din, d);
    end
    @(posedge clk);
    @(negedge clk);
    wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
  endtask

  // Offer one instruction; optionally drive a writeback during the capture
  // cycle of READ. Returns the number of edges after acceptance to op_valid.
  task automatic send(input logic [31:0] ins, input logic col_en, input logic [4:0] ca,
                      input logic [31:0] cd, output int lat);
    @(negedge clk);
    instr = ins; instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0; instr = '0;
    chk("instr_ready_in_read", {31'd0, instr_ready}, 32'd0);
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 1 && col_en) begin wb_valid = 1'b1; wb_addr = ca; wb_data = cd; end
      if (k == 2) begin wb_valid = 1'b0; wb_addr = '0; wb_data = '0; end
      if (op_valid) begin lat = k; break; end
    end
  endtask

  task automatic consume();
    @(negedge clk);
    op_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op_ready = 1'b0;
    chk("op_valid_after_consume", {31'd0, op_valid}, 32'd0);
    chk("instr_ready_after_consume", {31'd0, instr_ready}, 32'd1);
  endtask

  initial begin
    int lat;
    vecs[0] = '{6'h00, 5'd14, 5'd5,  5'd3,  32'h70CA7800, 32'h192489AC, 5'd3};
    vecs[1] = '{6'h00, 5'd0,  5'd5,  5'd7,  32'h00000000, 32'h192489AC, 5'd7};
    vecs[2] = '{6'h08, 5'd5,  5'd9,  5'd31, 32'h192489AC, 32'h00001234, 5'd9};
    vecs[3] = '{6'h00, 5'd5,  5'd14, 5'd0,  32'h192489AC, 32'h70CA7800, 5'd0};
    vecs[4] = '{6'h23, 5'd0,  5'd0,  5'd12, 32'h00000000, 32'h00000000, 5'd0};

    // Reset values, with writeback passing through during reset.
    #2;
    wb_valid = 1'b1; wb_addr = 5'd3;
    #1;
    chk("rst_op_valid", {31'd0, op_valid}, 32'd0);
    chk("rst_instr_ready", {31'd0, instr_ready}, 32'd1);
    chk("rst_rdaddr1", {27'd0, rf_rdaddr1}, 32'd0);
    chk("rst_rdaddr2", {27'd0, rf_rdaddr2}, 32'd0);
    chk("rst_op_a", op_a, 32'd0);
    chk("rst_op_dst", {27'd0, op_dst}, 32'd0);
    chk("rst_rf_wr", {31'd0, rf_wr}, 32'd1);
    wb_valid = 1'b0; wb_addr = '0;
    @(negedge clk);
    rst = 1'b0;

    wb_write(5'd5, 32'h192489AC);
    wb_write(5'd14, 32'h70CA7800);
    wb_write(5'd9, 32'h00001234);
    wb_write(5'd0, 32'hFFFFFFFF);

    for (int i = 0; i < 5; i++) begin
      send(mk(vecs[i].opc, vecs[i].rs, vecs[i].rt, vecs[i].rd), 1'b0, 5'd0, 32'd0, lat);
      chk($sformatf("v%0d_latency", i), lat, 32'd2);
      chk($sformatf("v%0d_op_a", i), op_a, vecs[i].exp_a);
      chk($sformatf("v%0d_op_b", i), op_b, vecs[i].exp_b);
      chk($sformatf("v%0d_op_dst", i), {27'd0, op_dst}, {27'd0, vecs[i].exp_dst});
      consume();
    end

    // Collision on rs.
    send(mk(6'h00, 5'd5, 5'd14, 5'd2), 1'b1, 5'd5, 32'h658921D3, lat);
    chk("col_latency", lat, COL_LAT);
    chk("col_op_a", op_a, 32'h658921D3);
    chk("col_op_b", op_b, 32'h70CA7800);
    consume();

    // $zero writeback during READ is not a collision.
    send(mk(6'h00, 5'd0, 5'd5, 5'd4), 1'b1, 5'd0, 32'hA5A5A5A5, lat);
    chk("zero_col_latency", lat, 32'd2);
    chk("zero_col_op_a", op_a, 32'd0);
    chk("zero_col_op_b", op_b, 32'h658921D3);
    consume();

    // Backpressure: operands held while a new instruction is offered.
    send(mk(6'h00, 5'd14, 5'd5, 5'd3), 1'b0, 5'd0, 32'd0, lat);
    chk("bp_latency", lat, 32'd2);
    instr = mk(6'h00, 5'd9, 5'd9, 5'd9); instr_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp_op_valid", {31'd0, op_valid}, 32'd1);
      chk("bp_instr_ready", {31'd0, instr_ready}, 32'd0);
      chk("bp_op_a", op_a, 32'h70CA7800);
      chk("bp_op_b", op_b, 32'h658921D3);
      chk("bp_op_dst", {27'd0, op_dst}, 32'd3);
    end
    instr_valid = 1'b0; instr = '0;
    consume();

    // Asynchronous reset during the capture cycle of READ.
    @(negedge clk);
    instr = mk(6'h00, 5'd14, 5'd5, 5'd6); instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0; instr = '0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_read_rdaddr1", {27'd0, rf_rdaddr1}, 32'd14);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_op_valid", {31'd0, op_valid}, 32'd0);
    chk("mid_rst_instr_ready", {31'd0, instr_ready}, 32'd1);
    chk("mid_rst_rdaddr1", {27'd0, rf_rdaddr1}, 32'd0);
    chk("mid_rst_rdaddr2", {27'd0, rf_rdaddr2}, 32'd0);
    chk("mid_rst_op_a", op_a, 32'd0);
    chk("mid_rst_op_dst", {27'd0, op_dst}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    send(mk(6'h08, 5'd14, 5'd9, 5'd1), 1'b0, 5'd0, 32'd0, lat);
    chk("post_rst_latency", lat, 32'd2);
    chk("post_rst_op_a", op_a, 32'h70CA7800);
    chk("post_rst_op_b", op_b, 32'h00001234);
    chk("post_rst_op_dst", {27'd0, op_dst}, 32'd9);
    consume();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
